// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MAC transmit scheduler: link speed encodings,
// nanoseconds-per-byte at each speed, and the scheduler FSM state type.
package mac_sched_pkg;

  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_10   = 2'b00;

  localparam int unsigned NS_PER_B_1000 = 32'd8;
  localparam int unsigned NS_PER_B_100  = 32'd80;
  localparam int unsigned NS_PER_B_10   = 32'd800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_GRANT = 2'd2,
    ST_BUSY  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mac_sched_timecalc.sv
// Schedule-phase arithmetic for the TX scheduler. Registers, one cycle after
// the inputs: whether the phase is inside the TTE window, the ns remaining
// until the window opens (modulo the schedule period), whether no window is
// configured, and the wire time of the BE head frame at the current speed.
module mac_sched_timecalc
  import mac_sched_pkg::*;
#(
  parameter int PHASE_W = 20,
  parameter int LEN_W   = 11,
  parameter int OVH_B   = 20,
  parameter int BE_W    = LEN_W + 10
) (
  input  logic               clk,
  input  logic               rst_sys,
  input  logic [1:0]         speed,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] win_start,
  input  logic [PHASE_W-1:0] win_len,
  input  logic [LEN_W-1:0]   len,
  output logic               in_win_r,
  output logic               no_win_r,
  output logic [PHASE_W-1:0] to_win_r,
  output logic [BE_W-1:0]    be_ns_r
);

  logic [PHASE_W-1:0] rel_s;
  logic [PHASE_W-1:0] to_win_s;
  logic               in_win_s;
  logic               no_win_s;
  logic [BE_W-1:0]    nspb_s;
  logic [BE_W-1:0]    bytes_s;
  logic [BE_W-1:0]    be_ns_s;

  // Window position and BE frame duration; subtraction wraps naturally at 2^PHASE_W.
  always_comb begin
    rel_s    = phase - win_start;
    to_win_s = win_start - phase;
    no_win_s = (win_len == {PHASE_W{1'b0}});
    if (no_win_s) begin
      in_win_s = 1'b0;
    end else begin
      in_win_s = (rel_s < win_len);
    end
    case (speed)
      SPD_1000: nspb_s = BE_W'(NS_PER_B_1000);
      SPD_100:  nspb_s = BE_W'(NS_PER_B_100);
      SPD_10:   nspb_s = BE_W'(NS_PER_B_10);
      default:  nspb_s = BE_W'(NS_PER_B_10);
    endcase
    bytes_s = BE_W'(len) + BE_W'(OVH_B);
    be_ns_s = bytes_s * nspb_s;
  end

  // Pipeline register holding the phase terms used by the EVAL decision.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      in_win_r <= 1'b0;
      no_win_r <= 1'b0;
      to_win_r <= {PHASE_W{1'b0}};
      be_ns_r  <= {BE_W{1'b0}};
    end else begin
      in_win_r <= in_win_s;
      no_win_r <= no_win_s;
      to_win_r <= to_win_s;
      be_ns_r  <= be_ns_s;
    end
  end

endmodule

// File: rtl/mac_tx_sched.sv
// Transmit scheduler between the TTE/BE pointer FIFOs and the GMII TX MAC.
// TTE has strict priority; with gating on, TTE only starts inside its window
// and BE only starts if it finishes (plus guard time) before the window opens.
// Optional build macro MAC_TX_SCHED_STATS_EN adds grant/defer statistics.
module mac_tx_sched
  import mac_sched_pkg::*;
#(
  parameter int PHASE_W  = 20,
  parameter int LEN_W    = 11,
  parameter int GUARD_NS = 96,
  parameter int OVH_B    = 20
) (
  input  logic               clk,
  input  logic               rst_sys,
  input  logic [1:0]         speed,
  input  logic [31:0]        counter_ns,
  input  logic               cfg_gate_en,
  input  logic [PHASE_W-1:0] cfg_win_start,
  input  logic [PHASE_W-1:0] cfg_win_len,
  input  logic               tptr_empty,
  input  logic [15:0]        tptr_din,
  output logic               tptr_rd,
  input  logic               bptr_empty,
  input  logic [15:0]        bptr_din,
  output logic               bptr_rd,
  output logic               out_valid,
  output logic [15:0]        out_ptr,
  output logic               out_tte,
  input  logic               out_ready,
  input  logic               tx_done
`ifdef MAC_TX_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_tte_cnt,
  output logic [31:0]        stat_be_cnt,
  output logic [31:0]        stat_defer_cnt
`endif
);

  localparam int BE_W  = LEN_W + 10;
  // Wide enough that be_ns + GUARD_NS and to_win never wrap in the compare.
  localparam int CMP_W = BE_W + 2;

  sched_state_e       state_r, state_s;
  logic               out_valid_r, out_valid_s;
  logic [15:0]        out_ptr_r, out_ptr_s;
  logic               out_tte_r, out_tte_s;
  logic               pop_s;
  logic               in_win_r, no_win_r;
  logic [PHASE_W-1:0] to_win_r;
  logic [BE_W-1:0]    be_ns_r;
  logic               fit_s, tte_ok_s, be_ok_s;
  logic               unused_s;

  assign unused_s = ^counter_ns[31:PHASE_W];

  mac_sched_timecalc #(
    .PHASE_W (PHASE_W),
    .LEN_W   (LEN_W),
    .OVH_B   (OVH_B),
    .BE_W    (BE_W)
  ) u_timecalc (
    .clk       (clk),
    .rst_sys   (rst_sys),
    .speed     (speed),
    .phase     (counter_ns[PHASE_W-1:0]),
    .win_start (cfg_win_start),
    .win_len   (cfg_win_len),
    .len       (bptr_din[LEN_W-1:0]),
    .in_win_r  (in_win_r),
    .no_win_r  (no_win_r),
    .to_win_r  (to_win_r),
    .be_ns_r   (be_ns_r)
  );

  // Gate qualification: TTE needs the window, BE needs to clear it with guard.
  always_comb begin
    fit_s    = ((CMP_W'(be_ns_r) + CMP_W'(GUARD_NS)) <= CMP_W'(to_win_r));
    tte_ok_s = !cfg_gate_en || in_win_r;
    be_ok_s  = !cfg_gate_en || (!in_win_r && (no_win_r || fit_s));
  end

  // Next-state and grant-register logic for IDLE/EVAL/GRANT/BUSY.
  always_comb begin
    state_s     = state_r;
    out_valid_s = out_valid_r;
    out_ptr_s   = out_ptr_r;
    out_tte_s   = out_tte_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!tptr_empty || !bptr_empty) begin
          state_s = ST_EVAL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (!tptr_empty && tte_ok_s) begin
          state_s     = ST_GRANT;
          out_valid_s = 1'b1;
          out_ptr_s   = tptr_din;
          out_tte_s   = 1'b1;
        end else if (!bptr_empty && be_ok_s) begin
          state_s     = ST_GRANT;
          out_valid_s = 1'b1;
          out_ptr_s   = bptr_din;
          out_tte_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          state_s     = ST_BUSY;
          out_valid_s = 1'b0;
          pop_s       = 1'b1;
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_BUSY: begin
        if (tx_done) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // FSM state and grant registers.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_ptr_r   <= 16'h0000;
      out_tte_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= out_valid_s;
      out_ptr_r   <= out_ptr_s;
      out_tte_r   <= out_tte_s;
    end
  end

  // The pop must coincide with the accept cycle, so it is decoded, not registered.
  assign tptr_rd   = pop_s && out_tte_r && !rst_sys;
  assign bptr_rd   = pop_s && !out_tte_r && !rst_sys;
  assign out_valid = out_valid_r;
  assign out_ptr   = out_ptr_r;
  assign out_tte   = out_tte_r;

`ifdef MAC_TX_SCHED_STATS_EN
  logic accept_s, defer_s;

  assign accept_s = (state_r == ST_GRANT) && out_ready;
  assign defer_s  = (state_r == ST_EVAL) && !bptr_empty && !be_ok_s;

  // Free-running wrap-around grant and defer counters.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      stat_tte_cnt   <= 32'd0;
      stat_be_cnt    <= 32'd0;
      stat_defer_cnt <= 32'd0;
    end else begin
      if (accept_s && out_tte_r) begin
        stat_tte_cnt <= stat_tte_cnt + 32'd1;
      end
      if (accept_s && !out_tte_r) begin
        stat_be_cnt <= stat_be_cnt + 32'd1;
      end
      if (defer_s) begin
        stat_defer_cnt <= stat_defer_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_tx_sched.sv
// Self-checking bench for mac_tx_sched: a table of single-grant vectors with
// hand-computed decisions, plus sequences for priority, back-pressure, defer,
// and reset in GRANT/BUSY. Stats checks only when MAC_TX_SCHED_STATS_EN is set.
module tb_mac_tx_sched;

  logic        clk = 1'b0;
  logic        rst_sys = 1'b1;
  logic [1:0]  speed = 2'b10;
  logic [31:0] counter_ns = 32'd0;
  logic        cfg_gate_en = 1'b0;
  logic [19:0] cfg_win_start = 20'd0;
  logic [19:0] cfg_win_len = 20'd0;
  logic        tptr_empty = 1'b1;
  logic [15:0] tptr_din = 16'hC123;
  logic        tptr_rd;
  logic        bptr_empty = 1'b1;
  logic [15:0] bptr_din = 16'h8040;
  logic        bptr_rd;
  logic        out_valid;
  logic [15:0] out_ptr;
  logic        out_tte;
  logic        out_ready = 1'b0;
  logic        tx_done = 1'b0;
`ifdef MAC_TX_SCHED_STATS_EN
  logic [31:0] stat_tte_cnt, stat_be_cnt, stat_defer_cnt;
`endif

  int total = 0;
  int bad = 0;

  localparam logic [15:0] TW = 16'hC123;

  mac_tx_sched dut (
    .clk(clk), .rst_sys(rst_sys), .speed(speed), .counter_ns(counter_ns),
    .cfg_gate_en(cfg_gate_en), .cfg_win_start(cfg_win_start), .cfg_win_len(cfg_win_len),
    .tptr_empty(tptr_empty), .tptr_din(tptr_din), .tptr_rd(tptr_rd),
    .bptr_empty(bptr_empty), .bptr_din(bptr_din), .bptr_rd(bptr_rd),
    .out_valid(out_valid), .out_ptr(out_ptr), .out_tte(out_tte),
    .out_ready(out_ready), .tx_done(tx_done)
`ifdef MAC_TX_SCHED_STATS_EN
    , .stat_tte_cnt(stat_tte_cnt), .stat_be_cnt(stat_be_cnt), .stat_defer_cnt(stat_defer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gate;
    logic [1:0]  spd;
    logic [19:0] ws;
    logic [19:0] wl;
    logic [19:0] ph;
    logic        tp;
    logic        bp;
    logic [15:0] bw;
    logic        eg;
    logic        et;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic gate, input logic [1:0] spd, input logic [19:0] ws,
                              input logic [19:0] wl, input logic [19:0] ph, input logic tp,
                              input logic bp, input logic [15:0] bw, input logic eg, input logic et);
    vec_t v;
    v.gate = gate; v.spd = spd; v.ws = ws; v.wl = wl; v.ph = ph;
    v.tp = tp; v.bp = bp; v.bw = bw; v.eg = eg; v.et = et;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_sys = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output logic found);
    found = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; tx_done = 1'b1;
    @(posedge clk); #1; tx_done = 1'b0;
  endtask

  task automatic set_phase(input logic [19:0] ph);
    counter_ns = {12'h5A5, ph};
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic found;
    @(posedge clk); #1;
    cfg_gate_en = v.gate; speed = v.spd; cfg_win_start = v.ws; cfg_win_len = v.wl;
    set_phase(v.ph);
    tptr_empty = !v.tp; bptr_empty = !v.bp; bptr_din = v.bw; tptr_din = TW;
    out_ready = 1'b0;
    do_reset();
    wait_valid(8, found);
    chk1($sformatf("v%0d_grant", idx), found, v.eg);
    if (found && v.eg) begin
      chk1($sformatf("v%0d_tte", idx), out_tte, v.et);
      chk32($sformatf("v%0d_ptr", idx), {16'h0, out_ptr}, {16'h0, (v.et ? TW : v.bw)});
      @(posedge clk); #1; out_ready = 1'b1;
      @(negedge clk);
      chk1($sformatf("v%0d_trd", idx), tptr_rd, v.et);
      chk1($sformatf("v%0d_brd", idx), bptr_rd, !v.et);
      @(posedge clk); #1; out_ready = 1'b0; tptr_empty = 1'b1; bptr_empty = 1'b1;
      @(negedge clk);
      chk1($sformatf("v%0d_vdrop", idx), out_valid, 1'b0);
      pulse_done();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic ok;
    //        gate spd    ws        wl      ph        tp   bp   bw       eg   et
    vecs[0]  = mk(1'b0, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b1, 1'b1, 16'h8040, 1'b1, 1'b1);
    vecs[1]  = mk(1'b0, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8040, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8040, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h85DC, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 2'b10, 20'hFFF9C, 20'd300, 20'd50, 1'b1, 1'b1, 16'h8040, 1'b1, 1'b1);
    vecs[5]  = mk(1'b1, 2'b10, 20'hFFF9C, 20'd300, 20'd50, 1'b0, 1'b1, 16'h8040, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd1000, 1'b1, 1'b0, 16'h8040, 1'b1, 1'b1);
    vecs[7]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd1499, 1'b1, 1'b0, 16'h8040, 1'b1, 1'b1);
    vecs[8]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd1500, 1'b1, 1'b0, 16'h8040, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b1, 1'b1, 16'h8040, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h805D, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 2'b10, 20'd1000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h805E, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 2'b00, 20'd1000, 20'd0, 20'd0, 1'b0, 1'b1, 16'h85DC, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 2'b00, 20'd1000, 20'd0, 20'd0, 1'b1, 1'b0, 16'h85DC, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 2'b01, 20'd7000, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8040, 1'b1, 1'b0);
    vecs[15] = mk(1'b1, 2'b01, 20'd6815, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8040, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 2'b11, 20'd16096, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);
    vecs[17] = mk(1'b1, 2'b11, 20'd16095, 20'd500, 20'd0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0);
    vecs[18] = mk(1'b1, 2'b10, 20'd300, 20'd5, 20'hFFF9C, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0);

    // Reset state
    do_reset();
    @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk32("rst_ptr", {16'h0, out_ptr}, 32'h0);
    chk1("rst_tte", out_tte, 1'b0);
    chk1("rst_trd", tptr_rd, 1'b0);
    chk1("rst_brd", bptr_rd, 1'b0);

    for (int i = 0; i < 19; i++) begin
      run_vec(vecs[i], i);
    end

    // Gate off, both pending, ready high: TTE first, then BE after tx_done
    @(posedge clk); #1;
    cfg_gate_en = 1'b0; speed = 2'b10; cfg_win_start = 20'd1000; cfg_win_len = 20'd500;
    set_phase(20'd0); tptr_empty = 1'b0; bptr_empty = 1'b0; bptr_din = 16'h8040;
    out_ready = 1'b1;
    do_reset();
    wait_valid(8, found);
    chk1("pri_found1", found, 1'b1);
    chk1("pri_tte1", out_tte, 1'b1);
    chk1("pri_trd1", tptr_rd, 1'b1);
    chk1("pri_brd1", bptr_rd, 1'b0);
    @(posedge clk); #1; tptr_empty = 1'b1;
    @(negedge clk);
    chk1("pri_trd_once", tptr_rd, 1'b0);
    wait_valid(4, found);
    chk1("pri_busy_hold", found, 1'b0);
    pulse_done();
    wait_valid(6, found);
    chk1("pri_found2", found, 1'b1);
    chk1("pri_tte2", out_tte, 1'b0);
    chk1("pri_brd2", bptr_rd, 1'b1);
    chk32("pri_ptr2", {16'h0, out_ptr}, 32'h0000_8040);
    @(posedge clk); #1; bptr_empty = 1'b1; out_ready = 1'b0;
    @(negedge clk);
`ifdef MAC_TX_SCHED_STATS_EN
    chk32("stat_tte", stat_tte_cnt, 32'd1);
    chk32("stat_be", stat_be_cnt, 32'd1);
`endif
    pulse_done();

    // Long BE deferred before the window; TTE granted once the window opens
    @(posedge clk); #1;
    cfg_gate_en = 1'b1; speed = 2'b10; cfg_win_start = 20'd1000; cfg_win_len = 20'd500;
    set_phase(20'd0); tptr_empty = 1'b0; bptr_empty = 1'b0; bptr_din = 16'h85DC;
    out_ready = 1'b0;
    do_reset();
    wait_valid(10, found);
    chk1("defer_nogrant", found, 1'b0);
`ifdef MAC_TX_SCHED_STATS_EN
    chk1("defer_cnt", stat_defer_cnt >= 32'd3, 1'b1);
`endif
    @(posedge clk); #1; set_phase(20'd1000);
    wait_valid(8, found);
    chk1("defer_win_found", found, 1'b1);
    chk1("defer_win_tte", out_tte, 1'b1);

    // Back-pressure: grant held 10 cycles, stray tx_done ignored, rd on accept only
    @(posedge clk); #1;
    cfg_gate_en = 1'b0; tptr_empty = 1'b1; bptr_empty = 1'b0; bptr_din = 16'h8123;
    out_ready = 1'b0;
    do_reset();
    wait_valid(8, found);
    chk1("bp_found", found, 1'b1);
    pulse_done();
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || out_ptr !== 16'h8123 || out_tte || tptr_rd || bptr_rd) ok = 1'b0;
    end
    chk1("bp_stable", ok, 1'b1);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_brd", bptr_rd, 1'b1);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk1("bp_brd_once", bptr_rd, 1'b0);
    chk1("bp_vdrop", out_valid, 1'b0);
    wait_valid(4, found);
    chk1("bp_busy_hold", found, 1'b0);
    pulse_done();
    wait_valid(6, found);
    chk1("bp_regrant", found, 1'b1);

    // Reset while in GRANT with the accept offered
    @(posedge clk); #1;
    tptr_empty = 1'b0; bptr_empty = 1'b1; out_ready = 1'b0;
    do_reset();
    wait_valid(8, found);
    chk1("rg_found", found, 1'b1);
    @(posedge clk); #1; rst_sys = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk1("rg_nopop", tptr_rd, 1'b0);
    @(posedge clk); #1; rst_sys = 1'b0; out_ready = 1'b0; tptr_empty = 1'b1;
    @(negedge clk);
    chk1("rg_valid", out_valid, 1'b0);
    chk32("rg_ptr", {16'h0, out_ptr}, 32'h0);
    chk1("rg_tte", out_tte, 1'b0);
`ifdef MAC_TX_SCHED_STATS_EN
    chk32("rg_stat_clr", stat_be_cnt, 32'd0);
`endif

    // Reset while in BUSY; afterwards the FSM must behave as IDLE
    @(posedge clk); #1; tptr_empty = 1'b0; out_ready = 1'b1;
    wait_valid(8, found);
    chk1("rb_found", found, 1'b1);
    chk1("rb_trd", tptr_rd, 1'b1);
    @(posedge clk); #1; rst_sys = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk1("rb_nopop", tptr_rd, 1'b0);
    @(posedge clk); #1; rst_sys = 1'b0;
    @(negedge clk);
    chk1("rb_valid", out_valid, 1'b0);
    chk32("rb_ptr", {16'h0, out_ptr}, 32'h0);
    chk1("rb_tte", out_tte, 1'b0);
    wait_valid(4, found);
    chk1("rb_idle_regrant", found, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
